// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer.
package bus_timer_pkg;

  // Register offsets relative to the timer base address
  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PRESC  = 3'd1,
    REG_RELOAD = 3'd2,
    REG_COUNT  = 3'd3,
    REG_STATUS = 3'd4
  } tmr_reg_e;

  localparam int unsigned NUM_REGS  = 5;

  // CTRL bit indices
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_IE   = 1;
  localparam int unsigned CTRL_AUTO = 2;

  // STATUS bit index
  localparam int unsigned STAT_PEND = 0;

  // Position of the timer interrupt in the CPU interrupt vector
  localparam int unsigned INT_TIMER = 0;

endpackage

// File: rtl/bus_timer_if.sv
// CPU data-bus responder interface for the timer.
interface bus_timer_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] addr;
  logic              ctrl;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              hit;

  modport master (output addr, ctrl, wdata, input rdata, hit);
  modport slave  (input addr, ctrl, wdata, output rdata, hit);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: pcnt runs 0..presc while enabled, ticking once per wrap.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q, pcnt_d;

  // Tick on the terminal count; a count above a freshly lowered presc wraps silently
  always_comb begin
    tick   = en && (pcnt_q == presc);
    pcnt_d = pcnt_q + PRESC_W'(1);
    if (!en || clr || (pcnt_q >= presc)) begin
      pcnt_d = '0;
    end
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level interrupt.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] BASE_ADDR = 16'hFF40,
  parameter int unsigned       PRESC_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  bus_timer_if.slave  bus,
  output logic        int_timer
);

  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               auto_q, auto_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DATA_W-1:0]  reload_q, reload_d;
  logic [DATA_W-1:0]  count_q, count_d;
  logic               pend_q, pend_d;

  logic [DATA_W-1:0]  off;
  logic               hit;
  logic               wr;
  tmr_reg_e           sel;
  logic               tick;
  logic               expire;
  logic               presc_clr;

  // Address decode: unsigned offset wraps below the base, so one compare covers both bounds
  always_comb begin
    off       = bus.addr - BASE_ADDR;
    hit       = (off <= DATA_W'(NUM_REGS - 1));
    sel       = tmr_reg_e'(off[2:0]);
    wr        = bus.ctrl && hit;
    presc_clr = wr && (sel == REG_CTRL) && bus.wdata[CTRL_EN] && !en_q;
  end

  assign bus.hit = hit;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .presc (presc_q),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Zero-wait-state read mux
  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (sel)
        REG_CTRL: begin
          bus.rdata[CTRL_EN]   = en_q;
          bus.rdata[CTRL_IE]   = ie_q;
          bus.rdata[CTRL_AUTO] = auto_q;
        end
        REG_PRESC:  bus.rdata[PRESC_W-1:0] = presc_q;
        REG_RELOAD: bus.rdata = reload_q;
        REG_COUNT:  bus.rdata = count_q;
        REG_STATUS: bus.rdata[STAT_PEND] = pend_q;
        default:    bus.rdata = '0;
      endcase
    end
  end

  // Next state: tick step first, then bus writes layered on top.
  // W1C is skipped on an expire so the set wins; a CTRL write overrides the one-shot EN clear.
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    auto_d   = auto_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    pend_d   = pend_q;
    expire   = en_q && tick && (count_q == '0);

    if (en_q && tick) begin
      if (count_q != '0) begin
        count_d = count_q - DATA_W'(1);
      end else begin
        pend_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr) begin
      case (sel)
        REG_CTRL: begin
          en_d   = bus.wdata[CTRL_EN];
          ie_d   = bus.wdata[CTRL_IE];
          auto_d = bus.wdata[CTRL_AUTO];
          if (bus.wdata[CTRL_EN] && !en_q) begin
            count_d = reload_q;
          end
        end
        REG_PRESC:  presc_d  = bus.wdata[PRESC_W-1:0];
        REG_RELOAD: reload_d = bus.wdata;
        REG_COUNT:  count_d  = bus.wdata;
        REG_STATUS: begin
          if (bus.wdata[STAT_PEND] && !expire) begin
            pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      auto_q   <= 1'b0;
      presc_q  <= '0;
      reload_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      ie_q     <= ie_d;
      auto_q   <= auto_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign int_timer = pend_q & ie_q;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: behavioural model plus directed and random stimulus.
module tb_bus_timer;

  localparam int BASE = 'hFF40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic int_timer;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  bus_timer_if #(.DATA_W(16)) bus ();

  bus_timer #(
    .DATA_W    (16),
    .BASE_ADDR (16'hFF40),
    .PRESC_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .int_timer (int_timer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model state (plain integers)
  int m_en = 0, m_ie = 0, m_auto = 0, m_presc = 0, m_reload = 0, m_count = 0, m_pend = 0, m_pcnt = 0;
  int n_en, n_ie, n_auto, n_presc, n_reload, n_count, n_pend, n_pcnt;
  int mo, wd;
  bit mwr, mtick, mexp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one step of the timer rules per clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_ie = 0; m_auto = 0; m_presc = 0;
      m_reload = 0; m_count = 0; m_pend = 0; m_pcnt = 0;
    end else begin
      mo    = int'(bus.addr) - BASE;
      wd    = int'(bus.wdata);
      mwr   = bus.ctrl && mo >= 0 && mo <= 4;
      mtick = (m_en != 0) && (m_pcnt == m_presc);
      mexp  = mtick && m_count == 0;
      n_en = m_en; n_ie = m_ie; n_auto = m_auto; n_presc = m_presc;
      n_reload = m_reload; n_count = m_count; n_pend = m_pend;
      n_pcnt = (m_en == 0 || m_pcnt >= m_presc) ? 0 : m_pcnt + 1;
      if (mtick) begin
        if (m_count != 0) n_count = m_count - 1;
        else begin
          n_pend = 1;
          if (m_auto != 0) n_count = m_reload;
          else n_en = 0;
        end
      end
      if (mwr) begin
        case (mo)
          0: begin
            n_en = wd & 1; n_ie = (wd >> 1) & 1; n_auto = (wd >> 2) & 1;
            if ((wd & 1) != 0 && m_en == 0) begin
              n_count = m_reload;
              n_pcnt  = 0;
            end
          end
          1: n_presc  = wd & 'hFF;
          2: n_reload = wd;
          3: n_count  = wd;
          4: if ((wd & 1) != 0 && !mexp) n_pend = 0;
          default: ;
        endcase
      end
      m_en = n_en; m_ie = n_ie; m_auto = n_auto; m_presc = n_presc;
      m_reload = n_reload; m_count = n_count; m_pend = n_pend; m_pcnt = n_pcnt;
    end
  end

  // Compare process: every negative edge, outputs against the model
  int e_off, e_rd;
  bit e_hit;
  always @(negedge clk) begin
    if (chk_en) begin
      e_off = int'(bus.addr) - BASE;
      e_hit = e_off >= 0 && e_off <= 4;
      case (e_off)
        0: e_rd = m_en | (m_ie << 1) | (m_auto << 2);
        1: e_rd = m_presc;
        2: e_rd = m_reload;
        3: e_rd = m_count;
        4: e_rd = m_pend;
        default: e_rd = 0;
      endcase
      chk("cmp_hit", 32'(bus.hit), 32'(e_hit));
      chk("cmp_rdata", 32'(bus.rdata), 32'(e_rd));
      chk("cmp_int", 32'(int_timer), 32'(m_pend & m_ie));
    end
  end

  // Bus write lasting one clock edge; called and returns at posedge+1
  task automatic wr(input int off, input int d);
    bus.addr  = 16'(BASE + off);
    bus.ctrl  = 1'b1;
    bus.wdata = 16'(d);
    @(posedge clk); #1;
    bus.ctrl  = 1'b0;
  endtask

  task automatic rdchk(input string name, input int off, input int exp);
    bus.addr = 16'(BASE + off);
    #2;
    chk(name, 32'(bus.rdata), 32'(exp));
    @(posedge clk); #1;
  endtask

  // Wait for PEND to rise (bounded), record the edge number, then clear it with W1C
  task automatic wait_rise(input string name, output int r, output logic irq);
    r   = -1;
    irq = 1'b0;
    bus.addr = 16'(BASE + 4);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.rdata[0]) begin
        r   = cyc;
        irq = int_timer;
        break;
      end
    end
    if (r < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no expire within 200 cycles", name);
    end else begin
      wr(4, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r1, r2, r3, r4, r5, r6, r7, a, off;
    logic irq;

    bus.addr  = '0;
    bus.ctrl  = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state and address window
    for (int i = -2; i <= 6; i++) begin
      a = BASE + i;
      bus.addr = 16'(a);
      #2;
      chk("rst_hit", 32'(bus.hit), (i >= 0 && i <= 4) ? 32'd1 : 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_int", 32'(int_timer), 32'd0);
      @(posedge clk); #1;
    end

    // One-shot: PRESC=0, RELOAD=3, EN|IE
    wr(1, 0); wr(2, 3); wr(0, 3);
    w = cyc;
    wait_rise("oneshot", r1, irq);
    chk("oneshot_lat", 32'(r1 - w), 32'd4);
    chk("oneshot_irq", 32'(irq), 32'd1);
    chk("model_oneshot_en", 32'(m_en), 32'd0);
    chk("oneshot_int_clr", 32'(int_timer), 32'd0);
    rdchk("oneshot_ctrl", 0, 2);
    rdchk("oneshot_count", 3, 0);
    bus.addr = 16'(BASE + 4);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("oneshot_no_reexpire", 32'(bus.rdata), 32'd0);
    end

    // Auto-reload with prescale: PRESC=2, RELOAD=4, EN|AUTO -> 15-cycle period
    wr(0, 0); wr(1, 2); wr(2, 4); wr(0, 5);
    w = cyc;
    wait_rise("auto1", r1, irq);
    chk("auto_first", 32'(r1 - w), 32'd15);
    chk("auto_irq_masked", 32'(irq), 32'd0);
    wait_rise("auto2", r2, irq);
    chk("auto_period2", 32'(r2 - r1), 32'd15);
    wait_rise("auto3", r3, irq);
    chk("auto_period3", 32'(r3 - r2), 32'd15);

    // W1C race on the expire edge; IE set without disturbing the running count
    wr(0, 7);
    for (int i = 0; i < 40 && cyc < r3 + 14; i++) begin
      @(posedge clk); #1;
    end
    bus.addr  = 16'(BASE + 4);
    bus.ctrl  = 1'b1;
    bus.wdata = 16'd1;
    @(posedge clk); #1;
    bus.ctrl  = 1'b0;
    chk("race_pend", 32'(bus.rdata), 32'd1);
    chk("race_int", 32'(int_timer), 32'd1);
    wr(4, 1);
    chk("w1c_pend", 32'(bus.rdata), 32'd0);
    chk("w1c_int", 32'(int_timer), 32'd0);

    // Live writes: RELOAD change applies from the next period; COUNT write restarts the countdown
    wr(2, 9);
    wait_rise("live1", r4, irq);
    chk("live_cur_period", 32'(r4 - (r3 + 15)), 32'd15);
    wait_rise("live2", r5, irq);
    chk("live_new_period", 32'(r5 - r4), 32'd30);
    wr(3, 1);
    wait_rise("live3", r6, irq);
    chk("live_count_wr", 32'(r6 - r5), 32'd6);
    wait_rise("live4", r7, irq);
    chk("live_after_count", 32'(r7 - r6), 32'd30);

    // Random bus traffic checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      off = int'($urandom_range(0, 11)) - 4;
      bus.addr  = 16'(BASE + off);
      bus.ctrl  = ($urandom_range(0, 3) == 0);
      bus.wdata = (off >= 1 && off <= 3) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      @(posedge clk); #1;
    end
    bus.ctrl = 1'b0;

    // Asynchronous reset mid-count
    wr(0, 0); wr(1, 50); wr(2, 5); wr(0, 1); wr(3, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.rdata), 32'd0);
    chk("async_rst_int", 32'(int_timer), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= 4; i++) rdchk("rst_reg", i, 0);
    #3 rst_n = 1'b1;
    bus.addr = 16'(BASE + 4);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("post_rst_int", 32'(int_timer), 32'd0);
      chk("post_rst_pend", 32'(bus.rdata), 32'd0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
